// File: rtl/melody_pkg.sv
// Shared types and defaults for the melody sequencer: FSM states, sample rate divider and output amplitude.
// Also holds the helper that turns the square-wave phase into a signed 32-bit sample.
package melody_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PLAY,
        ST_PAUSE
    } state_t;

    localparam int          DEF_SAMPLE_DIV = 1042;
    localparam logic [31:0] DEF_AMPLITUDE  = 32'd200000000;

    function automatic logic [31:0] square_sample(input logic snd, input logic [31:0] amp);
        return snd ? amp : (~amp + 32'd1);
    endfunction

endpackage

// File: rtl/melody_sequencer_tone_gen.sv
// Square-wave generator: toggles snd every 'period' enabled cycles; period 0 is a rest and holds the output.
// One-cycle latency from enable to toggle; clear restarts the phase with snd low.
module tone_gen (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] period,
    input  logic        enable,
    input  logic        clear,
    output logic        snd
);

    logic [31:0] ph_cnt;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            ph_cnt <= '0;
            snd    <= 1'b0;
        end else if (enable && period != 32'd0) begin
            if (ph_cnt >= period - 32'd1) begin
                ph_cnt <= '0;
                snd    <= ~snd;
            end else begin
                ph_cnt <= ph_cnt + 32'd1;
            end
        end
    end

endmodule

// File: rtl/melody_sequencer.sv
// Steps through an external note table, plays each note as a square wave and emits one sample per SAMPLE_DIV clocks.
// Samples are written only when the audio FIFO has space; a full FIFO drops the slot and pulses underrun.
module melody_sequencer
    import melody_pkg::*;
#(
    parameter int          NUM_NOTES  = 19,
    parameter int          ADDR_W     = 5,
    parameter int          SAMPLE_DIV = DEF_SAMPLE_DIV,
    parameter logic [31:0] AMPLITUDE  = DEF_AMPLITUDE
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              loop_en,
    input  logic              mute,
    output logic [ADDR_W-1:0] note_addr,
    input  logic [31:0]       note_period,
    input  logic [31:0]       note_duration,
    input  logic              audio_out_allowed,
    output logic              write_audio_out,
    output logic [31:0]       left_channel_audio_out,
    output logic [31:0]       right_channel_audio_out,
    output logic              busy,
    output logic              done,
    output logic              underrun
);

    state_t      state;
    logic [31:0] period_reg;
    logic [31:0] dur_reg;
    logic [31:0] dur_cnt;
    logic [31:0] sample_cnt;
    logic        snd;
    logic        running;
    logic        slot;
    logic        note_end;
    logic        last_note;
    logic [31:0] sample_val;

    // PAUSE with pause released counts like PLAY, so a pause of N cycles delays the note by exactly N.
    assign running    = (state == ST_PLAY || state == ST_PAUSE) && !pause;
    assign slot       = (state != ST_IDLE) && (sample_cnt == 32'(SAMPLE_DIV - 1));
    assign note_end   = (dur_cnt == dur_reg - 32'd1);
    assign last_note  = (note_addr == ADDR_W'(NUM_NOTES - 1));
    assign sample_val = (state == ST_PLAY && !mute && period_reg != 32'd0)
                        ? square_sample(snd, AMPLITUDE) : 32'd0;
    assign busy       = (state != ST_IDLE);

    tone_gen u_tone_gen (
        .clk    (CLOCK_50),
        .reset  (reset),
        .period (period_reg),
        .enable (running),
        .clear  (state == ST_LOAD),
        .snd    (snd)
    );

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state                   <= ST_IDLE;
            note_addr               <= '0;
            period_reg              <= '0;
            dur_reg                 <= '0;
            dur_cnt                 <= '0;
            sample_cnt              <= '0;
            write_audio_out         <= 1'b0;
            underrun                <= 1'b0;
            done                    <= 1'b0;
            left_channel_audio_out  <= '0;
            right_channel_audio_out <= '0;
        end else begin
            done            <= 1'b0;
            write_audio_out <= 1'b0;
            underrun        <= 1'b0;

            if (slot) begin
                if (audio_out_allowed) begin
                    write_audio_out         <= 1'b1;
                    left_channel_audio_out  <= sample_val;
                    right_channel_audio_out <= sample_val;
                end else begin
                    underrun <= 1'b1;
                end
            end

            if (state == ST_IDLE || slot) begin
                sample_cnt <= '0;
            end else begin
                sample_cnt <= sample_cnt + 32'd1;
            end

            if (state == ST_IDLE) begin
                if (start) begin
                    state     <= ST_LOAD;
                    note_addr <= '0;
                end
            end else if (stop) begin
                state      <= ST_IDLE;
                sample_cnt <= '0;
            end else if (start) begin
                state     <= ST_LOAD;
                note_addr <= '0;
            end else if (state == ST_LOAD) begin
                period_reg <= note_period;
                dur_reg    <= (note_duration == 32'd0) ? 32'd1 : note_duration;
                dur_cnt    <= '0;
                state      <= ST_PLAY;
            end else if (pause) begin
                state <= ST_PAUSE;
            end else begin
                state   <= ST_PLAY;
                dur_cnt <= dur_cnt + 32'd1;
                if (note_end) begin
                    if (!last_note) begin
                        note_addr <= note_addr + ADDR_W'(1);
                        state     <= ST_LOAD;
                    end else if (loop_en) begin
                        note_addr <= '0;
                        state     <= ST_LOAD;
                    end else begin
                        done       <= 1'b1;
                        state      <= ST_IDLE;
                        sample_cnt <= '0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed and randomized scenarios for melody_sequencer, checked cycle by cycle against a note-schedule model.
module tb_melody_sequencer;

    localparam int N    = 3;
    localparam int DIV  = 8;
    localparam int AMP  = 200000000;
    localparam int MAXC = 256;

    logic        clk = 1'b0;
    logic        reset, start, stop, pause, loop_en, mute, allowed;
    logic [4:0]  note_addr;
    logic [31:0] note_period, note_duration;
    logic        write_audio_out, busy, done, underrun;
    logic [31:0] left_out, right_out;

    logic [31:0] tbl_per [32];
    logic [31:0] tbl_dur [32];

    assign note_period   = tbl_per[note_addr];
    assign note_duration = tbl_dur[note_addr];

    always #5 clk = ~clk;

    melody_sequencer #(
        .NUM_NOTES (N),
        .ADDR_W    (5),
        .SAMPLE_DIV(DIV),
        .AMPLITUDE (32'd200000000)
    ) dut (
        .CLOCK_50               (clk),
        .reset                  (reset),
        .start                  (start),
        .stop                   (stop),
        .pause                  (pause),
        .loop_en                (loop_en),
        .mute                   (mute),
        .note_addr              (note_addr),
        .note_period            (note_period),
        .note_duration          (note_duration),
        .audio_out_allowed      (allowed),
        .write_audio_out        (write_audio_out),
        .left_channel_audio_out (left_out),
        .right_channel_audio_out(right_out),
        .busy                   (busy),
        .done                   (done),
        .underrun               (underrun)
    );

    // Model record per cycle: st 0=idle 1=load 2=play 3=paused, note index, position within note.
    typedef struct {
        int st;
        int addr;
        int j;
    } rec_t;

    rec_t sched[$];
    int   done_cyc;
    int   vectors = 0;
    int   miscompares = 0;
    int   cur_cyc;
    bit   allowed_v [MAXC];
    bit   mute_v [MAXC];
    int   len, pause_at, stop_at, reset_at;
    bit   stop_start, loop_v;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cur_cyc, obs, exp);
        end
    endtask

    task automatic set_table(input int d0, d1, d2, p0, p1, p2);
        tbl_dur[0] = 32'(d0); tbl_dur[1] = 32'(d1); tbl_dur[2] = 32'(d2);
        tbl_per[0] = 32'(p0); tbl_per[1] = 32'(p1); tbl_per[2] = 32'(p2);
    endtask

    task automatic clear_opts(input int l);
        len = l; pause_at = -1; stop_at = -1; reset_at = -1; stop_start = 0; loop_v = 0;
        for (int i = 0; i < MAXC; i++) begin
            allowed_v[i] = 1'b1;
            mute_v[i]    = 1'b0;
        end
    endtask

    // Lay out the ideal playback: one load cycle then 'duration' play cycles per note.
    task automatic build_base();
        sched.delete();
        done_cyc = -1;
        sched.push_back('{0, 0, 0});
        while (sched.size() < len + 60) begin
            for (int k = 0; k < N; k++) begin
                int d = (tbl_dur[k] == 0) ? 1 : int'(tbl_dur[k]);
                sched.push_back('{1, k, 0});
                for (int j = 0; j < d; j++) sched.push_back('{2, k, j});
            end
            if (!loop_v) begin
                done_cyc = sched.size();
                while (sched.size() < len + 60) sched.push_back('{0, N - 1, 0});
            end
        end
    endtask

    function automatic int find_play(input int a, input int jj);
        foreach (sched[i]) if (sched[i].st == 2 && sched[i].addr == a && sched[i].j == jj) return i;
        return -1;
    endfunction

    task automatic apply_mods();
        if (pause_at >= 0) begin
            for (int i = 0; i < 50; i++)
                sched.insert(pause_at + 1, '{3, sched[pause_at].addr, sched[pause_at].j});
            if (done_cyc > pause_at) done_cyc += 50;
        end
        if (stop_at >= 0) begin
            for (int i = stop_at + 1; i < sched.size(); i++) sched[i] = '{0, sched[stop_at].addr, 0};
            if (done_cyc > stop_at) done_cyc = -1;
        end
        if (reset_at >= 0) begin
            for (int i = reset_at + 1; i < sched.size(); i++) sched[i] = '{0, 0, 0};
            if (done_cyc > reset_at) done_cyc = -1;
        end
    endtask

    function automatic logic [31:0] exp_sample(input rec_t r, input bit m);
        int p = int'(tbl_per[r.addr]);
        if (r.st != 2 || m || p == 0) return 32'd0;
        return (((r.j / p) % 2) == 1) ? 32'(AMP) : 32'(-AMP);
    endfunction

    task automatic run_scenario();
        reset = 1; start = 0; stop = 0; pause = 0; mute = 0; allowed = 1; loop_en = loop_v;
        @(posedge clk); #1;
        reset = 0;
        cur_cyc = -1;
        chk("rst_busy", busy, 0);
        chk("rst_write", write_audio_out, 0);
        chk("rst_left", left_out, 0);
        chk("rst_addr", note_addr, 0);
        for (int e = 0; e < len; e++) begin
            bit slot;
            bit exp_wr;
            start   = (e == 0) || (e == stop_at && stop_start);
            stop    = (e == stop_at);
            pause   = (pause_at >= 0) && (e >= pause_at) && (e < pause_at + 50);
            allowed = allowed_v[e];
            mute    = mute_v[e];
            reset   = (e == reset_at);
            @(posedge clk); #1;
            cur_cyc = e + 1;
            slot   = (e >= 1) && (sched[e].st != 0) && (((e - 1) % DIV) == DIV - 1) && (e != reset_at);
            exp_wr = slot && allowed_v[e];
            chk("busy", busy, sched[e + 1].st != 0);
            chk("done", done, (e + 1) == done_cyc);
            chk("write", write_audio_out, exp_wr);
            chk("underrun", underrun, slot && !allowed_v[e]);
            if (sched[e + 1].st != 0) chk("note_addr", note_addr, sched[e + 1].addr);
            if (exp_wr) begin
                chk("left", left_out, exp_sample(sched[e], mute_v[e]));
                chk("right", right_out, exp_sample(sched[e], mute_v[e]));
            end
            if (e == reset_at) begin
                chk("mid_rst_left", left_out, 0);
                chk("mid_rst_right", right_out, 0);
                chk("mid_rst_addr", note_addr, 0);
            end
        end
        start = 0; stop = 0; pause = 0; reset = 0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            tbl_per[i] = '0;
            tbl_dur[i] = '0;
        end
        reset = 1; start = 0; stop = 0; pause = 0; loop_en = 0; mute = 0; allowed = 1;
        repeat (3) @(posedge clk);
        #1;
        cur_cyc = -1;
        chk("por_busy", busy, 0);
        chk("por_done", done, 0);
        chk("por_underrun", underrun, 0);
        chk("por_right", right_out, 0);

        // Basic pass: done 38 cycles after the start edge.
        set_table(10, 20, 5, 2, 3, 0);
        clear_opts(50); build_base(); apply_mods(); run_scenario();

        // Looping keeps busy and never pulses done.
        clear_opts(100); loop_v = 1; build_base(); apply_mods(); run_scenario();

        // Tone samples with period 4, muted for a window.
        set_table(12, 16, 20, 4, 4, 4);
        clear_opts(60);
        for (int i = 30; i < 42; i++) mute_v[i] = 1'b1;
        build_base(); apply_mods(); run_scenario();

        // FIFO full for the first three slots.
        set_table(10, 20, 5, 2, 3, 0);
        clear_opts(50);
        for (int i = 0; i < 32; i++) allowed_v[i] = 1'b0;
        build_base(); apply_mods(); run_scenario();

        // Pause 50 cycles in the middle of note 1.
        clear_opts(110); build_base(); pause_at = find_play(1, 5); apply_mods(); run_scenario();

        // start and stop together while playing.
        clear_opts(50); build_base(); stop_at = find_play(1, 3); stop_start = 1; apply_mods(); run_scenario();

        // Reset mid-note at dur_cnt 7.
        clear_opts(40); build_base(); reset_at = find_play(0, 7); apply_mods(); run_scenario();

        for (int r = 0; r < 6; r++) begin
            set_table($urandom_range(0, 12), $urandom_range(0, 12), $urandom_range(0, 12),
                      $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5));
            clear_opts(80);
            loop_v = 1'($urandom_range(0, 1));
            for (int i = 0; i < MAXC; i++) begin
                allowed_v[i] = ($urandom_range(0, 3) != 0);
                mute_v[i]    = ($urandom_range(0, 7) == 0);
            end
            build_base();
            if (r == 5) stop_at = $urandom_range(5, 30);
            if (stop_at >= 0 && sched[stop_at].st == 0) stop_at = -1;
            apply_mods();
            run_scenario();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
